// File: rtl/pcs_out_pkg.sv
// ----------------------------------------------------------------------------
// pcs_out_pkg
// Shared definitions for the multi-lane PCS encoder output selector:
//   - sel_state_e : mode-switch sequencer states
//   - IDLE_BLK    : control-idle block driven while the output is quiesced
//   - PRBS31_*    : tap positions of the x^31 + x^28 + 1 test-pattern LFSR
//   - sat_inc16   : saturating 16-bit increment for the switch counter
// ----------------------------------------------------------------------------
package pcs_out_pkg;

   typedef enum logic [1:0] {
      RUN_RAW = 2'd0,
      RUN_FEC = 2'd1,
      QUIESCE = 2'd2
   } sel_state_e;

   // Control-idle pattern; lanes narrower or wider than 64 bits take it
   // bit-wise modulo 64.
   localparam logic [63:0] IDLE_BLK = 64'h1E00_0000_0000_0000;

   // LFSR state bit positions (0-based) feeding the PRBS31 feedback XOR.
   localparam int PRBS31_LEN    = 31;
   localparam int PRBS31_TAP_HI = 30;   // x^31
   localparam int PRBS31_TAP_LO = 27;   // x^28

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/pcs_out_lane.sv
// ----------------------------------------------------------------------------
// pcs_out_lane
// Two-stage datapath for one lane.
//   Stage 1 (on s1_en): select test pattern / idle / FEC (GB65^PN2112) / GB66.
//   Stage 2 (on s2_en): optional bit reversal, then optional inversion.
// Both stages hold their contents when not enabled.
// Optional macro PCS_OUT_SEL_PRBS31_EN adds use_pat / pat_word.
// Ports:
//   CLK219, RST219_N   clock, synchronous active-low reset
//   use_pat, pat_word  test-pattern override (macro builds only)
//   s1_en, s2_en       stage enables (valid of the block entering each stage)
//   use_fec, use_idle  stage-1 source selection from the mode sequencer
//   swap, inv          stage-2 bit reversal / inversion enables
//   gb65_blk, pn2112_cw, gb66_blk  lane input blocks
//   out_blk            registered lane output
// ----------------------------------------------------------------------------
module pcs_out_lane
   import pcs_out_pkg::*;
#(
   parameter int DW = 64
) (
   input  logic          CLK219,
   input  logic          RST219_N,
`ifdef PCS_OUT_SEL_PRBS31_EN
   input  logic          use_pat,
   input  logic [DW-1:0] pat_word,
`endif
   input  logic          s1_en,
   input  logic          s2_en,
   input  logic          use_fec,
   input  logic          use_idle,
   input  logic          swap,
   input  logic          inv,
   input  logic [DW-1:0] gb65_blk,
   input  logic [DW-1:0] pn2112_cw,
   input  logic [DW-1:0] gb66_blk,
   output logic [DW-1:0] out_blk
);

   logic [DW-1:0] idle_w;
   logic [DW-1:0] sel_next;
   logic [DW-1:0] s1_reg;
   logic [DW-1:0] rev_w;
   logic [DW-1:0] s2_next;
   logic [DW-1:0] s2_reg;

   genvar gi;
   generate
      for (gi = 0; gi < DW; gi++) begin : g_bit
         assign idle_w[gi] = IDLE_BLK[gi % 64];
         assign rev_w[gi]  = s1_reg[DW-1-gi];
      end
   endgenerate

   always_comb begin
      sel_next = gb66_blk;
      if (use_fec)  sel_next = gb65_blk ^ pn2112_cw;
      if (use_idle) sel_next = idle_w;
`ifdef PCS_OUT_SEL_PRBS31_EN
      if (use_pat)  sel_next = pat_word;
`endif
   end

   // Reverse first, then invert.
   always_comb begin
      s2_next = swap ? rev_w : s1_reg;
      if (inv) s2_next = ~s2_next;
   end

   always_ff @(posedge CLK219) begin
      if (!RST219_N) begin
         s1_reg <= '0;
         s2_reg <= '0;
      end else begin
         if (s1_en) s1_reg <= sel_next;
         if (s2_en) s2_reg <= s2_next;
      end
   end

   assign out_blk = s2_reg;

endmodule

// File: rtl/vi_sync_level.sv
// ----------------------------------------------------------------------------
// vi_sync_level
// Multi-flop level synchroniser for quasi-static CSR inputs. Each bit is
// synchronised independently; consumers must tolerate a transient mix of old
// and new bits while a multi-bit field changes.
// Ports:
//   CLK219   destination clock
//   RST219_N synchronous active-low reset, clears all stages
//   d        asynchronous level input, W bits
//   q        synchronised level, STAGES cycles behind d
// ----------------------------------------------------------------------------
module vi_sync_level #(
   parameter int W      = 1,
   parameter int STAGES = 2
) (
   input  logic         CLK219,
   input  logic         RST219_N,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] stage_reg [STAGES];

   always_ff @(posedge CLK219) begin
      if (!RST219_N) begin
         for (int i = 0; i < STAGES; i++) stage_reg[i] <= '0;
      end else begin
         stage_reg[0] <= d;
         for (int i = 1; i < STAGES; i++) stage_reg[i] <= stage_reg[i-1];
      end
   end

   assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/pcs_out_sel_mlane.sv
// ----------------------------------------------------------------------------
// pcs_out_sel_mlane
// Multi-lane PCS encoder output selector with FEC mode-switch sequencing.
// A change of requested FEC mode quiesces all lanes with IDLE_BLK for
// CSR_QUIESCE_HOLD valid blocks, then commits the new mode at a block
// boundary. Latency IN_VLD -> ENC_OUT_VLD is 2 cycles.
// Optional macro PCS_OUT_SEL_PRBS31_EN adds CSR_TEST_PAT_ENA and a shared
// PRBS31 generator that overrides the stage-1 selection on all lanes.
// Ports:
//   CLK219, RST219_N          clock, synchronous active-low reset
//   CSR_TEST_PAT_ENA          PRBS31 test pattern enable (macro builds only)
//   IN_VLD                    block valid common to all lanes
//   GB65_BLK, PN2112_CW       FEC path block and scrambler codeword, per lane
//   GB66_BLK                  non-FEC path block, per lane
//   CSR_PCS_ENC_FEC_ENA       requested FEC mode
//   CSR_ENC_OUT_ENDIAN_SWAP   per-lane bit reversal enable
//   CSR_ENC_INV               per-lane inversion enable
//   CSR_QUIESCE_HOLD          idle blocks to insert on a mode switch
//   ENC_OUT_VLD, ENC_OUT_PMA_BLK  output valid and blocks to PMA
//   FEC_ACTIVE                committed mode
//   SWITCH_BUSY               sequencer is quiescing
//   SWITCH_CNT                completed mode switches, saturating
// ----------------------------------------------------------------------------
module pcs_out_sel_mlane
   import pcs_out_pkg::*;
#(
   parameter int NLANES      = 4,
   parameter int DW          = 64,
   parameter int HOLD_W      = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 CLK219,
   input  logic                 RST219_N,
`ifdef PCS_OUT_SEL_PRBS31_EN
   input  logic                 CSR_TEST_PAT_ENA,
`endif
   input  logic                 IN_VLD,
   input  logic [NLANES*DW-1:0] GB65_BLK,
   input  logic [NLANES*DW-1:0] PN2112_CW,
   input  logic [NLANES*DW-1:0] GB66_BLK,
   input  logic                 CSR_PCS_ENC_FEC_ENA,
   input  logic [NLANES-1:0]    CSR_ENC_OUT_ENDIAN_SWAP,
   input  logic [NLANES-1:0]    CSR_ENC_INV,
   input  logic [HOLD_W-1:0]    CSR_QUIESCE_HOLD,
   output logic                 ENC_OUT_VLD,
   output logic [NLANES*DW-1:0] ENC_OUT_PMA_BLK,
   output logic                 FEC_ACTIVE,
   output logic                 SWITCH_BUSY,
   output logic [15:0]          SWITCH_CNT
);

   // ---------------- CSR synchronisation ----------------
   localparam int BASE_W = 1 + 2*NLANES + HOLD_W;
`ifdef PCS_OUT_SEL_PRBS31_EN
   localparam int CSR_W = BASE_W + 1;
`else
   localparam int CSR_W = BASE_W;
`endif

   logic [CSR_W-1:0]  csr_raw;
   logic [CSR_W-1:0]  csr_sync;
   logic              fec_ena_s;
   logic [NLANES-1:0] swap_s;
   logic [NLANES-1:0] inv_s;
   logic [HOLD_W-1:0] hold_s;

`ifdef PCS_OUT_SEL_PRBS31_EN
   assign csr_raw = {CSR_TEST_PAT_ENA, CSR_QUIESCE_HOLD, CSR_ENC_INV,
                     CSR_ENC_OUT_ENDIAN_SWAP, CSR_PCS_ENC_FEC_ENA};
`else
   assign csr_raw = {CSR_QUIESCE_HOLD, CSR_ENC_INV,
                     CSR_ENC_OUT_ENDIAN_SWAP, CSR_PCS_ENC_FEC_ENA};
`endif

   vi_sync_level #(.W(CSR_W), .STAGES(SYNC_STAGES)) u_csr_sync (
      .CLK219   (CLK219),
      .RST219_N (RST219_N),
      .d        (csr_raw),
      .q        (csr_sync)
   );

   assign fec_ena_s = csr_sync[0];
   assign swap_s    = csr_sync[1 +: NLANES];
   assign inv_s     = csr_sync[1+NLANES +: NLANES];
   assign hold_s    = csr_sync[1+2*NLANES +: HOLD_W];

   // ---------------- mode-switch sequencer ----------------
   sel_state_e        state_reg;
   logic              fec_active_reg;
   logic [HOLD_W-1:0] hold_cnt_reg;
   logic [15:0]       switch_cnt_reg;
   logic              quiesce_w;

   assign quiesce_w = (state_reg == QUIESCE);

   always_ff @(posedge CLK219) begin
      if (!RST219_N) begin
         state_reg      <= RUN_RAW;
         fec_active_reg <= 1'b0;
         hold_cnt_reg   <= '0;
         switch_cnt_reg <= '0;
      end else begin
         case (state_reg)
            RUN_RAW, RUN_FEC: begin
               if (fec_ena_s != fec_active_reg) begin
                  if (hold_s == '0) begin
                     // Zero hold: commit now; the current block is still
                     // in the old mode, the next one is in the new mode.
                     fec_active_reg <= ~fec_active_reg;
                     switch_cnt_reg <= sat_inc16(switch_cnt_reg);
                     state_reg      <= fec_active_reg ? RUN_RAW : RUN_FEC;
                  end else begin
                     hold_cnt_reg <= hold_s;
                     state_reg    <= QUIESCE;
                  end
               end
            end
            QUIESCE: begin
               // Each valid block here is an idle block; the last one
               // closes the hold and commits (or abandons) the switch.
               if (IN_VLD) begin
                  if (hold_cnt_reg == HOLD_W'(1)) begin
                     hold_cnt_reg <= '0;
                     if (fec_ena_s != fec_active_reg) begin
                        fec_active_reg <= ~fec_active_reg;
                        switch_cnt_reg <= sat_inc16(switch_cnt_reg);
                        state_reg      <= fec_active_reg ? RUN_RAW : RUN_FEC;
                     end else begin
                        state_reg      <= fec_active_reg ? RUN_FEC : RUN_RAW;
                     end
                  end else begin
                     hold_cnt_reg <= hold_cnt_reg - HOLD_W'(1);
                  end
               end
            end
            default: state_reg <= RUN_RAW;
         endcase
      end
   end

   // ---------------- valid pipeline ----------------
   logic s1_vld_reg;
   logic out_vld_reg;

   always_ff @(posedge CLK219) begin
      if (!RST219_N) begin
         s1_vld_reg  <= 1'b0;
         out_vld_reg <= 1'b0;
      end else begin
         s1_vld_reg  <= IN_VLD;
         out_vld_reg <= s1_vld_reg;
      end
   end

`ifdef PCS_OUT_SEL_PRBS31_EN
   // ---------------- shared PRBS31 generator ----------------
   // Word bit 0 is the earliest bit of the sequence; the LFSR only advances
   // on blocks that actually carry the pattern.
   logic              test_pat_s;
   logic [PRBS31_LEN-1:0] prbs_reg;
   logic [PRBS31_LEN-1:0] prbs_next;
   logic [DW-1:0]     prbs_word;
   logic              prbs_fb;

   assign test_pat_s = csr_sync[CSR_W-1];

   always_comb begin
      prbs_next = prbs_reg;
      prbs_word = '0;
      prbs_fb   = 1'b0;
      for (int j = 0; j < DW; j++) begin
         prbs_fb      = prbs_next[PRBS31_TAP_HI] ^ prbs_next[PRBS31_TAP_LO];
         prbs_word[j] = prbs_fb;
         prbs_next    = {prbs_next[PRBS31_LEN-2:0], prbs_fb};
      end
   end

   always_ff @(posedge CLK219) begin
      if (!RST219_N)                 prbs_reg <= '1;
      else if (IN_VLD && test_pat_s) prbs_reg <= prbs_next;
   end
`endif

   // ---------------- per-lane datapath ----------------
   genvar gi;
   generate
      for (gi = 0; gi < NLANES; gi++) begin : g_lane
         pcs_out_lane #(.DW(DW)) u_lane (
            .CLK219    (CLK219),
            .RST219_N  (RST219_N),
`ifdef PCS_OUT_SEL_PRBS31_EN
            .use_pat   (test_pat_s),
            .pat_word  (prbs_word),
`endif
            .s1_en     (IN_VLD),
            .s2_en     (s1_vld_reg),
            .use_fec   (fec_active_reg),
            .use_idle  (quiesce_w),
            .swap      (swap_s[gi]),
            .inv       (inv_s[gi]),
            .gb65_blk  (GB65_BLK[gi*DW +: DW]),
            .pn2112_cw (PN2112_CW[gi*DW +: DW]),
            .gb66_blk  (GB66_BLK[gi*DW +: DW]),
            .out_blk   (ENC_OUT_PMA_BLK[gi*DW +: DW])
         );
      end
   endgenerate

   assign ENC_OUT_VLD = out_vld_reg;
   assign FEC_ACTIVE  = fec_active_reg;
   assign SWITCH_BUSY = quiesce_w;
   assign SWITCH_CNT  = switch_cnt_reg;

endmodule

// File: tb/tb_pcs_out_sel_mlane.sv
// ----------------------------------------------------------------------------
// tb_pcs_out_sel_mlane
// Scoreboard bench: the driver computes each block's expected output from a
// block-level mode model and queues it; a monitor pops and compares whenever
// ENC_OUT_VLD is seen, and checks that outputs hold while not valid.
// CSR changes are applied only while IN_VLD is low for several cycles, so
// the model may treat them as taking effect between blocks.
// ----------------------------------------------------------------------------
module tb_pcs_out_sel_mlane;

   localparam int NL = 4;
   localparam int DW = 64;
   localparam int HW = 8;
   localparam logic [63:0] IDLE = 64'h1E00_0000_0000_0000;

   logic              CLK219 = 1'b0;
   logic              RST219_N = 1'b0;
   logic              IN_VLD = 1'b0;
   logic [NL*DW-1:0]  GB65_BLK = '0;
   logic [NL*DW-1:0]  PN2112_CW = '0;
   logic [NL*DW-1:0]  GB66_BLK = '0;
   logic              CSR_PCS_ENC_FEC_ENA = 1'b0;
   logic [NL-1:0]     CSR_ENC_OUT_ENDIAN_SWAP = '0;
   logic [NL-1:0]     CSR_ENC_INV = '0;
   logic [HW-1:0]     CSR_QUIESCE_HOLD = '0;
`ifdef PCS_OUT_SEL_PRBS31_EN
   logic              CSR_TEST_PAT_ENA = 1'b0;
`endif
   logic              ENC_OUT_VLD;
   logic [NL*DW-1:0]  ENC_OUT_PMA_BLK;
   logic              FEC_ACTIVE;
   logic              SWITCH_BUSY;
   logic [15:0]       SWITCH_CNT;

   always #5 CLK219 = ~CLK219;

   pcs_out_sel_mlane #(.NLANES(NL), .DW(DW), .HOLD_W(HW), .SYNC_STAGES(2)) dut (
      .CLK219                  (CLK219),
      .RST219_N                (RST219_N),
`ifdef PCS_OUT_SEL_PRBS31_EN
      .CSR_TEST_PAT_ENA        (CSR_TEST_PAT_ENA),
`endif
      .IN_VLD                  (IN_VLD),
      .GB65_BLK                (GB65_BLK),
      .PN2112_CW               (PN2112_CW),
      .GB66_BLK                (GB66_BLK),
      .CSR_PCS_ENC_FEC_ENA     (CSR_PCS_ENC_FEC_ENA),
      .CSR_ENC_OUT_ENDIAN_SWAP (CSR_ENC_OUT_ENDIAN_SWAP),
      .CSR_ENC_INV             (CSR_ENC_INV),
      .CSR_QUIESCE_HOLD        (CSR_QUIESCE_HOLD),
      .ENC_OUT_VLD             (ENC_OUT_VLD),
      .ENC_OUT_PMA_BLK         (ENC_OUT_PMA_BLK),
      .FEC_ACTIVE              (FEC_ACTIVE),
      .SWITCH_BUSY             (SWITCH_BUSY),
      .SWITCH_CNT              (SWITCH_CNT)
   );

   typedef struct {
      int               cyc;
      logic [NL*DW-1:0] data;
   } exp_t;

   exp_t sb_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc   = 0;
   logic rst_d = 1'b0;

   always @(posedge CLK219) begin
      cyc   <= cyc + 1;
      rst_d <= RST219_N;
   end

   // ---------------- reference model state ----------------
   bit m_mode    = 1'b0;   // committed FEC mode
   int m_sw      = 0;      // completed switches
   bit m_quiesce = 1'b0;   // idle blocks still owed
   int m_idle_left = 0;
   bit m_target  = 1'b0;   // latest requested mode while quiescing
   bit m_pat     = 1'b0;   // test pattern active
   bit prbs_hist[$];       // recent PRBS31 bits, newest at the back

   task automatic prbs_reset();
      prbs_hist.delete();
      for (int i = 0; i < 31; i++) prbs_hist.push_back(1'b1);
   endtask

   // b[n] = b[n-31] ^ b[n-28]; first word bit is the earliest bit.
   function automatic logic [DW-1:0] prbs_model_word();
      logic [DW-1:0] w;
      int            n;
      bit            nb;
      w = '0;
      for (int j = 0; j < DW; j++) begin
         n  = prbs_hist.size();
         nb = prbs_hist[n-31] ^ prbs_hist[n-28];
         w[j] = nb;
         prbs_hist.push_back(nb);
      end
      while (prbs_hist.size() > 40) void'(prbs_hist.pop_front());
      return w;
   endfunction

   function automatic logic [DW-1:0] lane_post(input logic [DW-1:0] b, input bit sw, input bit iv);
      logic [DW-1:0] r;
      if (sw) r = {<<{b}};
      else    r = b;
      return iv ? ~r : r;
   endfunction

   function automatic logic [NL*DW-1:0] model_issue(input logic [NL*DW-1:0] g65,
                                                    input logic [NL*DW-1:0] pn,
                                                    input logic [NL*DW-1:0] g66);
      logic [NL*DW-1:0] e;
      logic [DW-1:0]    base;
      logic [DW-1:0]    pw;
      e  = '0;
      pw = '0;
      if (m_pat) pw = prbs_model_word();
      for (int l = 0; l < NL; l++) begin
         if (m_pat)          base = pw;
         else if (m_quiesce) base = IDLE;
         else if (m_mode)    base = g65[l*DW +: DW] ^ pn[l*DW +: DW];
         else                base = g66[l*DW +: DW];
         e[l*DW +: DW] = lane_post(base, CSR_ENC_OUT_ENDIAN_SWAP[l], CSR_ENC_INV[l]);
      end
      if (m_quiesce) begin
         m_idle_left--;
         if (m_idle_left == 0) begin
            m_quiesce = 1'b0;
            if (m_target != m_mode) begin
               m_mode = m_target;
               if (m_sw < 65535) m_sw++;
            end
         end
      end
      return e;
   endfunction

   // ---------------- checks ----------------
   task automatic chk(input string nm, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cyc %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic check_status();
      chk("fec_active", FEC_ACTIVE, m_mode);
      chk("switch_cnt", SWITCH_CNT, m_sw);
      chk("switch_busy", SWITCH_BUSY, m_quiesce);
   endtask

   // ---------------- monitor ----------------
   logic [NL*DW-1:0] last_out = '0;

   initial begin
      exp_t e;
      forever begin
         @(negedge CLK219);
         if (!rst_d) begin
            n_vec++;
            if (ENC_OUT_VLD !== 1'b0 || ENC_OUT_PMA_BLK !== '0) begin
               n_err++;
               $display("FAIL reset_state: vld %b blk %h, expected 0 (cyc %0d)", ENC_OUT_VLD, ENC_OUT_PMA_BLK, cyc);
            end
            last_out = '0;
         end else if (ENC_OUT_VLD === 1'b1) begin
            n_vec++;
            if (sb_q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_vld: output valid with empty scoreboard (cyc %0d)", cyc);
            end else begin
               e = sb_q.pop_front();
               if (ENC_OUT_PMA_BLK !== e.data || cyc != e.cyc) begin
                  n_err++;
                  $display("FAIL blk_data: got %h at cyc %0d, expected %h at cyc %0d", ENC_OUT_PMA_BLK, cyc, e.data, e.cyc);
               end else begin
                  $display("blk cyc %0d lane0 %h lane1 %h", cyc, ENC_OUT_PMA_BLK[0 +: DW], ENC_OUT_PMA_BLK[DW +: DW]);
               end
               last_out = e.data;
            end
         end else begin
            n_vec++;
            if (ENC_OUT_VLD !== 1'b0 || ENC_OUT_PMA_BLK !== last_out) begin
               n_err++;
               $display("FAIL hold: vld %b blk %h, expected held %h (cyc %0d)", ENC_OUT_VLD, ENC_OUT_PMA_BLK, last_out, cyc);
            end
         end
      end
   end

   // ---------------- driver ----------------
   function automatic logic [NL*DW-1:0] rnd_vec();
      logic [NL*DW-1:0] v;
      for (int l = 0; l < NL; l++) v[l*DW +: DW] = {$urandom, $urandom};
      return v;
   endfunction

   task automatic send(input bit vld, input logic [NL*DW-1:0] g65,
                       input logic [NL*DW-1:0] pn, input logic [NL*DW-1:0] g66,
                       input bit do_chk);
      exp_t e;
      @(negedge CLK219);
      if (do_chk) check_status();
      IN_VLD    = vld;
      GB65_BLK  = g65;
      PN2112_CW = pn;
      GB66_BLK  = g66;
      if (vld) begin
         e.cyc  = cyc + 2;
         e.data = model_issue(g65, pn, g66);
         sb_q.push_back(e);
      end
   endtask

   task automatic gap(input int n);
      for (int i = 0; i < n; i++) send(1'b0, rnd_vec(), rnd_vec(), rnd_vec(), 1'b0);
   endtask

   task automatic request(input bit fec, input int hold);
      @(negedge CLK219);
      IN_VLD              = 1'b0;
      CSR_QUIESCE_HOLD    = HW'(hold);
      CSR_PCS_ENC_FEC_ENA = fec;
      if (m_quiesce) begin
         m_target = fec;
      end else if (fec != m_mode) begin
         if (hold == 0) begin
            m_mode = fec;
            m_sw++;
         end else begin
            m_quiesce   = 1'b1;
            m_idle_left = hold;
            m_target    = fec;
         end
      end
      gap(6);
      check_status();
   endtask

   task automatic set_lane_ctl(input logic [NL-1:0] sw, input logic [NL-1:0] iv);
      @(negedge CLK219);
      IN_VLD                  = 1'b0;
      CSR_ENC_OUT_ENDIAN_SWAP = sw;
      CSR_ENC_INV             = iv;
      gap(5);
   endtask

   task automatic do_reset();
      @(negedge CLK219);
      IN_VLD              = 1'b0;
      RST219_N            = 1'b0;
      CSR_PCS_ENC_FEC_ENA = 1'b0;
      m_mode = 1'b0; m_sw = 0; m_quiesce = 1'b0; m_idle_left = 0; m_target = 1'b0;
      prbs_reset();
      repeat (3) @(negedge CLK219);
      RST219_N = 1'b1;
      gap(5);
   endtask

   task automatic burst(input int n, input bit all_valid);
      for (int i = 0; i < n; i++)
         send(all_valid || ($urandom_range(0, 3) != 0), rnd_vec(), rnd_vec(), rnd_vec(), 1'b0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NL*DW-1:0] v;
      logic [NL*DW-1:0] ones;
      logic [NL*DW-1:0] g65_d;
      logic [NL*DW-1:0] pn_d;

      prbs_reset();
      for (int l = 0; l < NL; l++) begin
         ones [l*DW +: DW] = 64'h1;
         g65_d[l*DW +: DW] = 64'hFFFF_0000_FFFF_0000;
         pn_d [l*DW +: DW] = 64'h0F0F_0F0F_0F0F_0F0F;
      end

`ifdef PCS_OUT_SEL_PRBS31_EN
      // Test pattern from reset, complemented on lane 2.
      CSR_TEST_PAT_ENA = 1'b1;
      CSR_ENC_INV      = 4'b0100;
      m_pat            = 1'b1;
`endif
      repeat (4) @(negedge CLK219);
      RST219_N = 1'b1;
      gap(5);
      check_status();

`ifdef PCS_OUT_SEL_PRBS31_EN
      burst(4, 1'b1);
      @(negedge CLK219);
      IN_VLD           = 1'b0;
      CSR_TEST_PAT_ENA = 1'b0;
      m_pat            = 1'b0;
      set_lane_ctl(4'b0000, 4'b0000);
`endif

      // Raw mode, known lane-0 pattern, continuous valid.
      for (int i = 0; i < 8; i++) begin
         v = rnd_vec();
         v[0 +: DW] = 64'h0123_4567_89AB_CDEF;
         send(1'b1, rnd_vec(), rnd_vec(), v, 1'b0);
      end
      gap(4);
      check_status();

      // Switch to FEC with a hold of 3.
      request(1'b1, 3);
      for (int i = 0; i < 6; i++) send(1'b1, g65_d, pn_d, rnd_vec(), 1'b1);
      gap(4);
      check_status();

      // Back to raw with hold 4 and valid toggling every cycle.
      request(1'b0, 4);
      for (int i = 0; i < 10; i++) send(i % 2 == 0, rnd_vec(), rnd_vec(), rnd_vec(), 1'b1);
      gap(4);
      check_status();

      // Lane reversal / inversion with all-ones-LSB inputs.
      set_lane_ctl(4'b0010, 4'b0100);
      for (int i = 0; i < 4; i++) send(1'b1, ones, ones, ones, 1'b0);
      gap(4);
      set_lane_ctl(4'b0000, 4'b0000);

      // Request reverted during the hold: no switch.
      request(1'b1, 4);
      burst(2, 1'b1);
      request(1'b0, 4);
      for (int i = 0; i < 5; i++) send(1'b1, rnd_vec(), rnd_vec(), rnd_vec(), 1'b1);
      gap(4);
      check_status();

      // Randomised mix of requests, lane controls and bursts.
      for (int it = 0; it < 30; it++) begin
         case ($urandom_range(0, 3))
            0:       set_lane_ctl(NL'($urandom), NL'($urandom));
            1:       request(bit'($urandom_range(0, 1)), $urandom_range(0, 5));
            default: burst($urandom_range(3, 12), 1'b0);
         endcase
      end
      gap(4);
      check_status();

      // Reset in the middle of a pending switch.
      set_lane_ctl(4'b0000, 4'b0000);
      if (m_quiesce) burst(8, 1'b1);
      if (m_mode) begin
         request(1'b0, 0);
      end
      request(1'b1, 5);
      burst(2, 1'b1);
      gap(4);
      do_reset();
      check_status();
      for (int i = 0; i < 4; i++) send(1'b1, rnd_vec(), rnd_vec(), rnd_vec(), 1'b1);
      gap(4);
      check_status();

      // A further randomised stretch after reset.
      for (int it = 0; it < 20; it++) begin
         case ($urandom_range(0, 3))
            0:       set_lane_ctl(NL'($urandom), NL'($urandom));
            1:       request(bit'($urandom_range(0, 1)), $urandom_range(0, 5));
            default: burst($urandom_range(3, 12), 1'b0);
         endcase
      end
      gap(6);
      check_status();
      chk("scoreboard_empty", sb_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
